tile_spawner: RTL and testbench

Spawn controller for the 2048 board. On request it draws cell coordinates and a value bit from the free-running LFSR and retries while the drawn cell is occupied. After a bounded number of misses it falls back to a deterministic wrapping scan, then reports one empty cell and the new tile exponent. It sits between the game-move FSM (requester) and the board register file (writer); the LFSR stays a separate instance at top level.

---
 rtl/game_pkg.sv | 24 ++
 rtl/tile_spawner.sv | 139 +++++++++++++
 tb/tb_tile_spawner.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared 2048 board types and constants used by the tile spawner and its neighbours.
package game_pkg;

  localparam int BOARD_CELLS = 16;

  // Cell index is {y,x}, two bits each.
  typedef logic [3:0] cell_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TRY  = 3'd1,
    ST_SCAN = 3'd2,
    ST_DONE = 3'd3,
    ST_FULL = 3'd4
  } spawn_state_t;

  localparam logic [1:0] EXP_2 = 2'd1;
  localparam logic [1:0] EXP_4 = 2'd2;

  function automatic logic [1:0] exp_from_bit(input logic val_bit);
    return val_bit ? EXP_4 : EXP_2;
  endfunction

endpackage

// File: rtl/tile_spawner.sv
// Picks an empty board cell for a new tile: random LFSR draws first, then a
// wrapping linear scan once the draw budget is spent.
module tile_spawner #(
  parameter int MAX_TRIES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spawn_req,
  input  logic [15:0] board_occ,
  input  logic [1:0]  x_coor,
  input  logic [1:0]  y_coor,
  input  logic        rnd_num,
  output logic        spawn_busy,
  output logic        spawn_valid,
  output logic        spawn_none,
  output logic [1:0]  spawn_x,
  output logic [1:0]  spawn_y,
  output logic [1:0]  spawn_val
);
  import game_pkg::*;

  localparam logic [3:0]             LAST_TRY   = 4'(MAX_TRIES - 1);
  localparam logic [BOARD_CELLS-1:0] FULL_BOARD = {BOARD_CELLS{1'b1}};

  spawn_state_t state_r;
  spawn_state_t state_s;
  logic [3:0]   try_cnt_r;
  logic [3:0]   try_cnt_s;
  cell_idx_t    scan_idx_r;
  cell_idx_t    scan_idx_s;
  logic         val_bit_r;
  logic         val_bit_s;
  cell_idx_t    draw_idx_s;
  logic         load_s;
  cell_idx_t    load_cell_s;
  logic [1:0]   load_val_s;

  assign draw_idx_s = {y_coor, x_coor};

  // Next-state and result selection; board_occ is stable while busy.
  always_comb begin
    state_s     = state_r;
    try_cnt_s   = try_cnt_r;
    scan_idx_s  = scan_idx_r;
    val_bit_s   = val_bit_r;
    load_s      = 1'b0;
    load_cell_s = 4'd0;
    load_val_s  = 2'd0;
    case (state_r)
      ST_IDLE: begin
        if (spawn_req) begin
          if (board_occ == FULL_BOARD) begin
            state_s = ST_FULL;
          end else begin
            state_s   = ST_TRY;
            try_cnt_s = 4'd0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_TRY: begin
        if (!board_occ[draw_idx_s]) begin
          load_s      = 1'b1;
          load_cell_s = draw_idx_s;
          load_val_s  = exp_from_bit(rnd_num);
          state_s     = ST_DONE;
        end else if (try_cnt_r < LAST_TRY) begin
          try_cnt_s = try_cnt_r + 4'd1;
        end else begin
          // The scan starts just past the last missed draw and wraps 15 -> 0.
          scan_idx_s = draw_idx_s + 4'd1;
          val_bit_s  = rnd_num;
          state_s    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!board_occ[scan_idx_r]) begin
          load_s      = 1'b1;
          load_cell_s = scan_idx_r;
          load_val_s  = exp_from_bit(val_bit_r);
          state_s     = ST_DONE;
        end else begin
          scan_idx_s = scan_idx_r + 4'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      ST_FULL: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Working registers and outputs, all derived from the next state so they are flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      try_cnt_r   <= 4'd0;
      scan_idx_r  <= 4'd0;
      val_bit_r   <= 1'b0;
      spawn_busy  <= 1'b0;
      spawn_valid <= 1'b0;
      spawn_none  <= 1'b0;
      spawn_x     <= 2'd0;
      spawn_y     <= 2'd0;
      spawn_val   <= 2'd0;
    end else begin
      try_cnt_r   <= try_cnt_s;
      scan_idx_r  <= scan_idx_s;
      val_bit_r   <= val_bit_s;
      spawn_busy  <= (state_s != ST_IDLE);
      spawn_valid <= (state_s == ST_DONE);
      spawn_none  <= (state_s == ST_FULL);
      if (load_s) begin
        spawn_y   <= load_cell_s[3:2];
        spawn_x   <= load_cell_s[1:0];
        spawn_val <= load_val_s;
      end else begin
        spawn_y   <= spawn_y;
        spawn_x   <= spawn_x;
        spawn_val <= spawn_val;
      end
    end
  end

endmodule

// File: tb/tb_tile_spawner.sv
// Randomized bench for tile_spawner: each request's outcome and latency are
// worked out up front from the draw sequence, then checked cycle by cycle.
module tb_tile_spawner;
  localparam int MT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       spawn_req;
  logic [15:0] board_occ;
  logic [1:0] x_coor;
  logic [1:0] y_coor;
  logic       rnd_num;
  logic       spawn_busy;
  logic       spawn_valid;
  logic       spawn_none;
  logic [1:0] spawn_x;
  logic [1:0] spawn_y;
  logic [1:0] spawn_val;

  tile_spawner #(.MAX_TRIES(MT)) dut (
    .clk(clk), .rst(rst), .spawn_req(spawn_req), .board_occ(board_occ),
    .x_coor(x_coor), .y_coor(y_coor), .rnd_num(rnd_num),
    .spawn_busy(spawn_busy), .spawn_valid(spawn_valid), .spawn_none(spawn_none),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_val(spawn_val)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;
  logic exp_busy, exp_valid, exp_none;
  logic [1:0] exp_x, exp_y, exp_val;
  logic [1:0] cur_x, cur_y, cur_val;

  task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      cmp("busy",  8'(spawn_busy),  8'(exp_busy));
      cmp("valid", 8'(spawn_valid), 8'(exp_valid));
      cmp("none",  8'(spawn_none),  8'(exp_none));
      cmp("x",     8'(spawn_x),     8'(exp_x));
      cmp("y",     8'(spawn_y),     8'(exp_y));
      cmp("val",   8'(spawn_val),   8'(exp_val));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic b, input logic v, input logic n,
                         input logic [1:0] x, input logic [1:0] y, input logic [1:0] e);
    exp_busy = b; exp_valid = v; exp_none = n; exp_x = x; exp_y = y; exp_val = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      spawn_req = 1'b0;
      board_occ = 16'($urandom);
      {y_coor, x_coor} = 4'($urandom_range(0, 15));
      rnd_num = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  // One request from an IDLE cycle; returns the predicted latency and result.
  task automatic do_spawn(input logic [15:0] occ, input bit held, input logic [3:0] h_idx,
                          input logic h_rnd, input bit req_hold, input int abort_at,
                          output int lat, output logic [1:0] rx, output logic [1:0] ry,
                          output logic [1:0] rv);
    logic [3:0] di [1:MT];
    logic       dr [1:MT];
    logic [3:0] c;
    int hit;
    bit full;
    for (int n = 1; n <= MT; n++) begin
      di[n] = held ? h_idx : 4'($urandom_range(0, 15));
      dr[n] = held ? h_rnd : 1'($urandom_range(0, 1));
    end
    full = (occ == 16'hFFFF);
    hit = 0;
    rx = cur_x; ry = cur_y; rv = cur_val;
    lat = 1;
    if (!full) begin
      for (int n = 1; n <= MT; n++) begin
        if (hit == 0 && !occ[di[n]]) hit = n;
      end
      if (hit != 0) begin
        lat = hit + 1;
        {ry, rx} = di[hit];
        rv = dr[hit] ? 2'd2 : 2'd1;
      end else begin
        c = di[MT];
        lat = MT + 1;
        for (int s = 1; s <= 15; s++) begin
          c = c + 4'd1;
          if (!occ[c]) begin
            lat = MT + 1 + s;
            break;
          end
        end
        {ry, rx} = c;
        rv = dr[MT] ? 2'd2 : 2'd1;
      end
    end
    spawn_req = 1'b1;
    board_occ = occ;
    {y_coor, x_coor} = 4'($urandom_range(0, 15));
    rnd_num = 1'($urandom_range(0, 1));
    step();
    for (int t = 1; t <= lat; t++) begin
      if (t == lat && !full) set_exp(1'b1, 1'b1, 1'b0, rx, ry, rv);
      else set_exp(1'b1, 1'b0, (full && t == 1), cur_x, cur_y, cur_val);
      spawn_req = req_hold ? 1'b1 : 1'($urandom_range(0, 1));
      if (t <= MT) begin
        {y_coor, x_coor} = di[t];
        rnd_num = dr[t];
      end else begin
        {y_coor, x_coor} = 4'($urandom_range(0, 15));
        rnd_num = 1'($urandom_range(0, 1));
      end
      rst = (t == abort_at);
      step();
      if (t == abort_at) begin
        rst = 1'b0;
        cur_x = 2'd0; cur_y = 2'd0; cur_val = 2'd0;
        set_exp(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        spawn_req = 1'b0;
        return;
      end
    end
    cur_x = rx; cur_y = ry; cur_val = rv;
    set_exp(1'b0, 1'b0, 1'b0, cur_x, cur_y, cur_val);
    spawn_req = 1'b0;
  endtask

  initial begin
    int lat;
    logic [1:0] rx, ry, rv;
    logic [15:0] occ;
    logic [15:0] one;
    rst = 1'b1; spawn_req = 1'b0; board_occ = 16'h0;
    x_coor = 2'd0; y_coor = 2'd0; rnd_num = 1'b0;
    cur_x = 2'd0; cur_y = 2'd0; cur_val = 2'd0;
    set_exp(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    step();
    checking = 1'b1;
    spawn_req = 1'b1;
    step();
    rst = 1'b0;
    idle(2);

    // Empty board, draw (x=2,y=1), value bit 0.
    do_spawn(16'h0000, 1'b1, 4'd6, 1'b0, 1'b0, 0, lat, rx, ry, rv);
    cmp("t1_lat", 8'(lat), 8'd2);
    cmp("t1_x", 8'(rx), 8'd2); cmp("t1_y", 8'(ry), 8'd1); cmp("t1_val", 8'(rv), 8'd1);
    idle(1);

    // Full board: nothing spawned, outputs keep the previous tile.
    do_spawn(16'hFFFF, 1'b0, 4'd0, 1'b0, 1'b0, 0, lat, rx, ry, rv);
    cmp("t2_lat", 8'(lat), 8'd1);
    cmp("t2_x", 8'(rx), 8'd2); cmp("t2_y", 8'(ry), 8'd1);
    idle(1);

    // Draws stuck on occupied cell 5, only cell 6 empty -> scan finds it at step 1.
    do_spawn(16'hFFBF, 1'b1, 4'd5, 1'b1, 1'b0, 0, lat, rx, ry, rv);
    cmp("t3_lat", 8'(lat), 8'd10);
    cmp("t3_x", 8'(rx), 8'd2); cmp("t3_y", 8'(ry), 8'd1); cmp("t3_val", 8'(rv), 8'd2);
    idle(2);

    // Scan wraps from 15 to 0.
    do_spawn(16'hFFFE, 1'b1, 4'd15, 1'b0, 1'b0, 0, lat, rx, ry, rv);
    cmp("t4_lat", 8'(lat), 8'd10);
    cmp("t4_x", 8'(rx), 8'd0); cmp("t4_y", 8'(ry), 8'd0); cmp("t4_val", 8'(rv), 8'd1);

    // Request held high back to back on an empty board.
    for (int i = 0; i < 6; i++) begin
      do_spawn(16'h0000, 1'b0, 4'd0, 1'b0, 1'b1, 0, lat, rx, ry, rv);
    end
    idle(1);

    // Reset in the middle of a long scan, then a normal request.
    do_spawn(16'h7FFF, 1'b1, 4'd0, 1'b1, 1'b0, MT + 3, lat, rx, ry, rv);
    cmp("t6_lat", 8'(lat), 8'(MT + 16));
    idle(1);
    do_spawn(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 0, lat, rx, ry, rv);
    idle(1);

    for (int i = 0; i < 80; i++) begin
      one = 16'd1;
      case ($urandom_range(0, 4))
        0: occ = 16'h0000;
        1: occ = 16'($urandom);
        2: occ = 16'hFFFF ^ (one << $urandom_range(0, 15));
        3: occ = 16'hFFFF;
        default: occ = 16'($urandom) | 16'($urandom);
      endcase
      do_spawn(occ, 1'b0, 4'd0, 1'b0, ($urandom_range(0, 3) == 0), 0, lat, rx, ry, rv);
      idle($urandom_range(0, 3));
    end

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
